// File: rtl/serdes_cipher_receiver.sv
// serdes_cipher_receiver: deserialises MSB-first cipher bits, strips the key byte
// and queues the plaintext in a first-word-fall-through FIFO with sticky error flags.
module serdes_cipher_receiver #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               i_key,
  input  logic                     i_bit_in,
  input  logic                     i_bit_valid,
  input  logic                     i_frame_end,
  input  logic                     i_flush,
  output logic [7:0]               o_out_data,
  output logic                     o_out_valid,
  input  logic                     i_out_ready,
  output logic [$clog2(DEPTH):0]   o_fifo_count,
  output logic                     o_overflow,
  output logic                     o_frame_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    r_sr;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [CW-1:0] r_count;
  logic          r_overflow, r_frame_err;

  logic       w_done, w_bad, w_pop, w_full, w_push, w_drop;
  logic [7:0] w_byte;

  assign w_done = i_bit_valid && (r_bit_cnt == 3'd7);
  assign w_bad  = i_bit_valid && i_frame_end && (r_bit_cnt != 3'd7);
  assign w_byte = {r_sr[6:0], i_bit_in} ^ i_key;
  assign w_pop  = o_out_valid && i_out_ready;
  assign w_full = r_count == CW'(DEPTH);
  // A full FIFO still accepts a byte when the head leaves on the same edge.
  assign w_push = w_done && (!w_full || w_pop);
  assign w_drop = w_done && w_full && !w_pop;

  assign o_out_valid  = r_count != '0;
  assign o_out_data   = r_mem[r_rp];
  assign o_fifo_count = r_count;
  assign o_overflow   = r_overflow;
  assign o_frame_err  = r_frame_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr        <= '0;
      r_bit_cnt   <= '0;
      r_wp        <= '0;
      r_rp        <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_frame_err <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_flush) begin
      r_sr        <= '0;
      r_bit_cnt   <= '0;
      r_wp        <= '0;
      r_rp        <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_bad) begin
        r_sr        <= '0;
        r_bit_cnt   <= '0;
        r_frame_err <= 1'b1;
      end else if (i_bit_valid) begin
        r_sr      <= {r_sr[6:0], i_bit_in};
        r_bit_cnt <= r_bit_cnt + 3'd1;
      end
      if (w_push) begin
        r_mem[r_wp] <= w_byte;
        r_wp        <= r_wp + AW'(1);
      end
      if (w_pop) r_rp <= r_rp + AW'(1);
      if (w_drop) r_overflow <= 1'b1;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end
endmodule

// File: tb/tb_serdes_cipher_receiver.sv
// tb_serdes_cipher_receiver: directed test-plan steps plus random traffic, checked
// against a queue-based model of the receiver and FIFO.
module tb_serdes_cipher_receiver;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] key = 8'h00;
  logic       bit_in = 1'b0, bit_valid = 1'b0, frame_end = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic [7:0] out_data;
  logic       out_valid, overflow, frame_err;
  logic [$clog2(DEPTH):0] fifo_count;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] q[$];
  int         m_bits = 0;
  logic [7:0] m_acc = 8'h00;
  bit         m_ovf = 1'b0, m_ferr = 1'b0;

  serdes_cipher_receiver #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .i_key(key), .i_bit_in(bit_in), .i_bit_valid(bit_valid),
    .i_frame_end(frame_end), .i_flush(flush), .o_out_data(out_data), .o_out_valid(out_valid),
    .i_out_ready(out_ready), .o_fifo_count(fifo_count), .o_overflow(overflow), .o_frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_bits = 0;
    m_acc  = 8'h00;
    m_ovf  = 1'b0;
    m_ferr = 1'b0;
  endtask

  task automatic model_step();
    bit done = 1'b0;
    bit pop;
    if (flush) begin
      model_clear();
      return;
    end
    pop = (q.size() != 0) && out_ready;
    if (bit_valid) begin
      if (frame_end && m_bits != 7) begin
        m_ferr = 1'b1;
        m_bits = 0;
        m_acc  = 8'h00;
      end else begin
        m_acc = {m_acc[6:0], bit_in};
        m_bits++;
        if (m_bits == 8) begin
          done   = 1'b1;
          m_bits = 0;
        end
      end
    end
    if (pop) void'(q.pop_front());
    if (done) begin
      if (q.size() < DEPTH) q.push_back(m_acc ^ key);
      else m_ovf = 1'b1;
    end
  endtask

  task automatic check_all();
    chk("valid", out_valid, q.size() != 0);
    chk("count", fifo_count, q.size());
    if (q.size() != 0) chk("data", out_data, q[0]);
    chk("overflow", overflow, m_ovf);
    chk("frame_err", frame_err, m_ferr);
  endtask

  task automatic cyc(input logic bv, input logic b, input logic fe, input logic rdy, input logic fl);
    bit_valid = bv;
    bit_in    = b;
    frame_end = fe;
    out_ready = rdy;
    flush     = fl;
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic send(input logic [7:0] b, input logic fe, input logic rdy_last);
    for (int i = 0; i < 8; i++) cyc(1'b1, b[7-i], fe && i == 7, rdy_last && i == 7, 1'b0);
    bit_valid = 1'b0;
  endtask

  task automatic idle(input logic rdy);
    cyc(1'b0, 1'b0, 1'b0, rdy, 1'b0);
  endtask

  task automatic do_reset();
    bit_valid = 1'b0;
    frame_end = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    rst_n     = 1'b0;
    #1;
    model_clear();
    check_all();
    chk("rst_data", out_data, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] c3;
    c3 = 8'hC3;
    do_reset();

    // single byte
    key = 8'h5A;
    send(8'hC3, 1'b1, 1'b0);
    chk("single_data", out_data, 8'h99);
    chk("single_count", fifo_count, 1);
    idle(1'b1);
    chk("single_empty", out_valid, 1'b0);

    // fill and overflow
    key = 8'h00;
    for (int i = 1; i <= 4; i++) send(8'(i), 1'b1, 1'b0);
    chk("fill_count", fifo_count, 4);
    chk("fill_head", out_data, 8'h01);
    send(8'h05, 1'b1, 1'b0);
    chk("ovf_set", overflow, 1'b1);
    chk("ovf_count", fifo_count, 4);
    for (int i = 1; i <= 4; i++) begin
      chk("drain_order", out_data, 8'(i));
      idle(1'b1);
    end
    chk("drain_empty", out_valid, 1'b0);

    // full with simultaneous pop
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 4; i++) send(8'(i), 1'b1, 1'b0);
    send(8'h05, 1'b1, 1'b1);
    chk("fullpop_count", fifo_count, 4);
    chk("fullpop_ovf", overflow, 1'b0);
    for (int i = 2; i <= 5; i++) begin
      chk("fullpop_order", out_data, 8'(i));
      idle(1'b1);
    end

    // framing error on the 5th bit
    key = 8'h5A;
    for (int i = 0; i < 4; i++) cyc(1'b1, c3[7-i], 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("ferr_set", frame_err, 1'b1);
    chk("ferr_nopush", fifo_count, 0);
    send(8'hC3, 1'b1, 1'b0);
    chk("ferr_resync", out_data, 8'h99);
    idle(1'b1);
    chk("ferr_sticky", frame_err, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("ferr_flush", frame_err, 1'b0);

    // reset mid-operation
    send(8'h11, 1'b1, 1'b0);
    send(8'h22, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b1, c3[7-i], 1'b0, 1'b0, 1'b0);
    do_reset();
    key = 8'h5A;
    send(8'hC3, 1'b1, 1'b0);
    chk("post_rst_data", out_data, 8'h99);
    chk("post_rst_count", fifo_count, 1);

    // flush priority over completion and pop
    for (int i = 0; i < 7; i++) cyc(1'b1, c3[7-i], 1'b0, 1'b0, 1'b0);
    cyc(1'b1, c3[0], 1'b1, 1'b1, 1'b1);
    chk("flush_count", fifo_count, 0);
    send(8'hC3, 1'b1, 1'b0);
    chk("flush_bitcnt", out_data, 8'h99);
    idle(1'b1);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      logic bv, fe;
      if ($urandom_range(0, 15) == 0) key = 8'($urandom);
      bv = $urandom_range(0, 3) != 0;
      fe = bv && (m_bits == 7 ? $urandom_range(0, 3) != 0 : $urandom_range(0, 19) == 0);
      cyc(bv, 1'($urandom), fe, $urandom_range(0, 2) == 0, $urandom_range(0, 149) == 0);
      if (n == 300) do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
